soc_sysid_checker: RTL and testbench

Boot-time integrity checker and access arbiter for the SoC system-ID slave (32-bit ID word at address 0, build-timestamp word at address 1). After reset it reads both words, compares them against the values the software build expects, and publishes sticky pass/fail status. Afterwards it shares the slave's single read port with a CPU-side Avalon-MM master. It sits between the interconnect and the sysid slave in the `soc` top level.

---
 rtl/soc_sysid_checker.sv | 154 +++++++++++++++
 tb/tb_soc_sysid_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_sysid_checker.sv
// soc_sysid_checker: boot-time ID/timestamp integrity check of the sysid slave,
// then arbitration of the slave's single read port with a CPU Avalon-MM master.
module soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0100_0001,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5834_5328,
    parameter int unsigned READ_LATENCY       = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    input  logic        cpu_read,
    input  logic        cpu_address,
    output logic        cpu_waitrequest,
    output logic        cpu_readdatavalid,
    output logic [31:0] cpu_readdata,
    input  logic        recheck,
    output logic        check_done,
    output logic        id_match,
    output logic        ts_match,
    output logic        sysid_ok
);

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        CHK_ID = 2'd0,
        CHK_TS = 2'd1,
        IDLE   = 2'd2,
        CPU_RD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        addr_lat_q, addr_lat_d;
    logic        pending_q, pending_d;
    logic        check_done_q, check_done_d;
    logic        id_match_q, id_match_d;
    logic        ts_match_q, ts_match_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        sample;

    assign sample = (cnt_q == LAT);

    // Next-state logic: wait-counter sequencing, check results and CPU read capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_lat_d   = addr_lat_q;
        pending_d    = pending_q;
        check_done_d = check_done_q;
        id_match_d   = id_match_q;
        ts_match_d   = ts_match_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;

        // Rechecks arriving while busy collapse into a single pending request
        if (state_q != IDLE && recheck) begin
            pending_d = 1'b1;
        end

        case (state_q)
            CHK_ID: begin
                if (sample) begin
                    id_match_d = (sysid_readdata == EXPECTED_ID);
                    state_d    = CHK_TS;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            CHK_TS: begin
                if (sample) begin
                    ts_match_d   = (sysid_readdata == EXPECTED_TIMESTAMP);
                    check_done_d = 1'b1;
                    state_d      = IDLE;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (recheck || pending_q) begin
                    state_d      = CHK_ID;
                    check_done_d = 1'b0;
                    pending_d    = 1'b0;
                end else if (cpu_read) begin
                    addr_lat_d = cpu_address;
                    state_d    = CPU_RD;
                end
            end
            CPU_RD: begin
                if (sample) begin
                    rdata_d  = sysid_readdata;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = CHK_ID;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CHK_ID;
            cnt_q        <= '0;
            addr_lat_q   <= 1'b0;
            pending_q    <= 1'b0;
            check_done_q <= 1'b0;
            id_match_q   <= 1'b0;
            ts_match_q   <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_lat_q   <= addr_lat_d;
            pending_q    <= pending_d;
            check_done_q <= check_done_d;
            id_match_q   <= id_match_d;
            ts_match_q   <= ts_match_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    // Slave address decoded from the registered state
    always_comb begin
        sysid_address = 1'b0;
        case (state_q)
            CHK_TS:  sysid_address = 1'b1;
            CPU_RD:  sysid_address = addr_lat_q;
            default: sysid_address = 1'b0;
        endcase
    end

    assign cpu_waitrequest   = !(state_q == IDLE && !recheck && !pending_q);
    assign cpu_readdatavalid = rvalid_q;
    assign cpu_readdata      = rdata_q;
    assign check_done        = check_done_q;
    assign id_match          = id_match_q;
    assign ts_match          = ts_match_q;
    assign sysid_ok          = check_done_q & id_match_q & ts_match_q;

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Directed bench for soc_sysid_checker: one instance with READ_LATENCY=0 and one with 3.
module tb_soc_sysid_checker;

    localparam logic [31:0] ID = 32'h0100_0001;
    localparam logic [31:0] TS = 32'h5834_5328;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Instance with L=0
    logic        rst0 = 1'b0;
    logic        addr0;
    logic [31:0] rd0;
    logic [31:0] ts0_val = TS;
    logic        cpu_read0 = 1'b0, cpu_addr0 = 1'b0, recheck0 = 1'b0;
    logic        wait0, rvalid0, done0, idm0, tsm0, ok0;
    logic [31:0] rdata0;

    assign rd0 = addr0 ? ts0_val : ID;

    soc_sysid_checker #(
        .EXPECTED_ID(ID), .EXPECTED_TIMESTAMP(TS), .READ_LATENCY(0)
    ) dut0 (
        .clock(clock), .reset_n(rst0),
        .sysid_address(addr0), .sysid_readdata(rd0),
        .cpu_read(cpu_read0), .cpu_address(cpu_addr0),
        .cpu_waitrequest(wait0), .cpu_readdatavalid(rvalid0), .cpu_readdata(rdata0),
        .recheck(recheck0), .check_done(done0), .id_match(idm0),
        .ts_match(tsm0), .sysid_ok(ok0)
    );

    // Instance with L=3
    logic        rst3 = 1'b0;
    logic        addr3;
    logic [31:0] rd3;
    logic        cpu_read3 = 1'b0, cpu_addr3 = 1'b0, recheck3 = 1'b0;
    logic        wait3, rvalid3, done3, idm3, tsm3, ok3;
    logic [31:0] rdata3;

    assign rd3 = addr3 ? TS : ID;

    soc_sysid_checker #(
        .EXPECTED_ID(ID), .EXPECTED_TIMESTAMP(TS), .READ_LATENCY(3)
    ) dut3 (
        .clock(clock), .reset_n(rst3),
        .sysid_address(addr3), .sysid_readdata(rd3),
        .cpu_read(cpu_read3), .cpu_address(cpu_addr3),
        .cpu_waitrequest(wait3), .cpu_readdatavalid(rvalid3), .cpu_readdata(rdata3),
        .recheck(recheck3), .check_done(done3), .id_match(idm3),
        .ts_match(tsm3), .sysid_ok(ok3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; inputs change and outputs are sampled there
    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        // ---------------- reset values ----------------
        step(); step();
        chk("rst0_addr", addr0, 0);
        chk("rst0_wait", wait0, 1);
        chk("rst0_rvalid", rvalid0, 0);
        chk("rst0_rdata", rdata0, 0);
        chk("rst0_done", done0, 0);
        chk("rst0_idm", idm0, 0);
        chk("rst0_tsm", tsm0, 0);
        chk("rst0_ok", ok0, 0);

        // ---------------- boot check L=0 ----------------
        rst0 = 1'b1;
        step();
        chk("boot0_e1_done", done0, 0);
        chk("boot0_e1_addr", addr0, 1);
        step();
        chk("boot0_e2_done", done0, 1);
        chk("boot0_e2_idm", idm0, 1);
        chk("boot0_e2_tsm", tsm0, 1);
        chk("boot0_e2_ok", ok0, 1);
        chk("boot0_e2_wait", wait0, 0);

        // CPU read of address 0, L=0
        cpu_read0 = 1'b1; cpu_addr0 = 1'b0;
        step();
        cpu_read0 = 1'b0;
        chk("rd0_acc_wait", wait0, 1);
        chk("rd0_acc_rvalid", rvalid0, 0);
        step();
        chk("rd0_rvalid", rvalid0, 1);
        chk("rd0_rdata", rdata0, ID);
        step();
        chk("rd0_rvalid_pulse", rvalid0, 0);
        chk("rd0_idle_wait", wait0, 0);

        // ---------------- timestamp mismatch via recheck ----------------
        ts0_val = 32'h0000_0000;
        recheck0 = 1'b1;
        #1 chk("rck0_wait_comb", wait0, 1);
        step();
        recheck0 = 1'b0;
        chk("rck0_done_low", done0, 0);
        chk("rck0_ok_low", ok0, 0);
        chk("rck0_idm_hold", idm0, 1);
        chk("rck0_tsm_hold", tsm0, 1);
        step();
        chk("rck0_addr_ts", addr0, 1);
        step();
        chk("tsbad_done", done0, 1);
        chk("tsbad_idm", idm0, 1);
        chk("tsbad_tsm", tsm0, 0);
        chk("tsbad_ok", ok0, 0);

        // ---------------- recheck and cpu_read together ----------------
        ts0_val = TS;
        recheck0 = 1'b1; cpu_read0 = 1'b1; cpu_addr0 = 1'b1;
        step();
        recheck0 = 1'b0;
        chk("pri_done_low", done0, 0);
        chk("pri_wait", wait0, 1);
        step();
        chk("pri_wait2", wait0, 1);
        chk("pri_rvalid_none", rvalid0, 0);
        step();
        chk("pri_done_back", done0, 1);
        chk("pri_ok_back", ok0, 1);
        chk("pri_wait_idle", wait0, 0);
        step();
        cpu_read0 = 1'b0;
        chk("pri_rd_addr", addr0, 1);
        chk("pri_rd_rvalid0", rvalid0, 0);
        step();
        chk("pri_rd_rvalid", rvalid0, 1);
        chk("pri_rd_rdata", rdata0, TS);

        // ---------------- reset during a CPU read ----------------
        step();
        cpu_read0 = 1'b1; cpu_addr0 = 1'b0;
        step();
        cpu_read0 = 1'b0;
        chk("mid_rd_inflight", wait0, 1);
        rst0 = 1'b0;
        #1;
        chk("mid_rst_wait", wait0, 1);
        chk("mid_rst_rvalid", rvalid0, 0);
        chk("mid_rst_done", done0, 0);
        chk("mid_rst_idm", idm0, 0);
        chk("mid_rst_tsm", tsm0, 0);
        chk("mid_rst_ok", ok0, 0);
        chk("mid_rst_addr", addr0, 0);
        chk("mid_rst_rdata", rdata0, 32'h0000_0000);
        step();
        chk("mid_rst_rvalid_hold", rvalid0, 0);
        step();
        rst0 = 1'b1;
        step();
        chk("mid_boot_e1_rvalid", rvalid0, 0);
        chk("mid_boot_e1_done", done0, 0);
        step();
        chk("mid_boot_e2_done", done0, 1);
        chk("mid_boot_e2_ok", ok0, 1);
        chk("mid_boot_e2_rvalid", rvalid0, 0);

        // ---------------- L=3: CPU read held during boot check ----------------
        cpu_read3 = 1'b1; cpu_addr3 = 1'b1;
        rst3 = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk($sformatf("b3_e%0d_wait", i), wait3, 1);
            chk($sformatf("b3_e%0d_done", i), done3, 0);
            chk($sformatf("b3_e%0d_addr", i), addr3, (i >= 4) ? 1 : 0);
        end
        step();
        chk("b3_e8_done", done3, 1);
        chk("b3_e8_ok", ok3, 1);
        chk("b3_e8_wait", wait3, 0);
        step();
        cpu_read3 = 1'b0;
        chk("rd3_acc_addr", addr3, 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("rd3_n%0d_rvalid", i), rvalid3, 0);
        end
        step();
        chk("rd3_n4_rvalid", rvalid3, 1);
        chk("rd3_n4_rdata", rdata3, TS);
        step();
        chk("rd3_n5_rvalid", rvalid3, 0);

        // ---------------- L=3: two rechecks during CPU_RD ----------------
        cpu_read3 = 1'b1; cpu_addr3 = 1'b0;
        step();
        cpu_read3 = 1'b0;
        recheck3 = 1'b1;
        step();
        recheck3 = 1'b0;
        step();
        recheck3 = 1'b1;
        step();
        recheck3 = 1'b0;
        step();
        chk("dbl_rvalid", rvalid3, 1);
        chk("dbl_rdata", rdata3, ID);
        chk("dbl_wait_pending", wait3, 1);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("dbl_c%0d_addr", i), addr3, (i >= 5) ? 1 : 0);
            chk($sformatf("dbl_c%0d_done", i), done3, 0);
        end
        step();
        chk("dbl_end_done", done3, 1);
        chk("dbl_end_ok", ok3, 1);
        chk("dbl_end_wait", wait3, 0);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("dbl_after%0d_done", i), done3, 1);
            chk($sformatf("dbl_after%0d_addr", i), addr3, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
